// File: rtl/common.sv
// Shared core types and constants: operand widths, memory-op encodings,
// load/store funct3 codes, LSU state enum and store-formatting helpers.
package common;

   localparam int unsigned DATA_WIDTH    = 32;
   localparam int unsigned OPERAND_WIDTH = 32;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2
   } mem_op_type;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_GNT    = 2'd1,
      WAIT_RVALID = 2'd2
   } lsu_state_type;

   // Halfwords need addr[0]=0, words need addr[1:0]=00; bytes are always aligned.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3[1:0])
         2'b01:   return addr_lo[0];
         2'b10:   return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3[1:0])
         2'b00:   return 4'b0001 << addr_lo;
         2'b01:   return 4'b0011 << addr_lo;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] store_wdata(input logic [2:0] funct3,
                                                         input logic [DATA_WIDTH-1:0] data);
      case (funct3[1:0])
         2'b00:   return {4{data[7:0]}};
         2'b01:   return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Load data formatter: picks the addressed byte/halfword out of a 32-bit
// read word and sign- or zero-extends it according to funct3.
module load_formatter
   import common::*;
(
   input  logic [1:0]            addr_lo,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] rdata,
   output logic [DATA_WIDTH-1:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select followed by extension.
   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  load_data = {24'b0, byte_sel};
         F3_LHU:  load_data = {16'b0, half_sel};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs req/gnt/rvalid transactions for loads
// and stores, passes non-memory results through, and registers the
// write-back entry. Stalls upstream while a transaction is outstanding.
module mem_stage
   import common::*;
#(
   parameter int unsigned RESP_TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   input  logic [OPERAND_WIDTH-1:0] i_alu_result,
   input  logic [DATA_WIDTH-1:0]    i_rf_data2,
   input  logic [4:0]               i_rd,
   input  mem_op_type               i_mem_op,
   input  logic [2:0]               i_funct3,
   output logic                     o_stall,
   output logic                     dmem_req,
   output logic                     dmem_we,
   output logic [31:0]              dmem_addr,
   output logic [3:0]               dmem_be,
   output logic [DATA_WIDTH-1:0]    dmem_wdata,
   input  logic                     dmem_gnt,
   input  logic                     dmem_rvalid,
   input  logic [DATA_WIDTH-1:0]    dmem_rdata,
   output logic                     o_wb_valid,
   output logic [DATA_WIDTH-1:0]    o_wb_data,
   output logic [4:0]               o_wb_rd,
   output logic                     o_exc_misaligned,
   output logic                     o_exc_bus
);

   localparam int CNT_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);

   lsu_state_type           state_q, state_d;
   logic [CNT_W-1:0]        cnt_q;
   logic [31:0]             req_addr_q;
   logic [3:0]              req_be_q;
   logic [DATA_WIDTH-1:0]   req_wdata_q;
   logic                    req_we_q;
   logic [2:0]              req_f3_q;
   logic [1:0]              req_off_q;
   logic [4:0]              req_rd_q;

   logic                    is_mem, is_store, mis_now, timeout;
   logic [DATA_WIDTH-1:0]   load_data;

   assign is_store = (i_mem_op == MEM_STORE);
   assign is_mem   = (i_mem_op == MEM_LOAD) || is_store;
   assign mis_now  = is_misaligned(i_funct3, i_alu_result[1:0]);
   // Fires in the last WAIT_RVALID cycle, so the bus error pulses
   // RESP_TIMEOUT+1 cycles after the grant.
   assign timeout  = (state_q == WAIT_RVALID) && !dmem_rvalid &&
                     (cnt_q == CNT_W'(RESP_TIMEOUT - 1));

   load_formatter u_load_formatter (
      .addr_lo   (req_off_q),
      .funct3    (req_f3_q),
      .rdata     (dmem_rdata),
      .load_data (load_data)
   );

   // Next-state, stall and data-memory port drive.
   always_comb begin
      state_d    = state_q;
      o_stall    = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_be    = '0;
      dmem_wdata = '0;
      case (state_q)
         IDLE: begin
            if (i_valid && is_mem && !mis_now) begin
               dmem_req   = 1'b1;
               dmem_we    = is_store;
               dmem_addr  = {i_alu_result[OPERAND_WIDTH-1:2], 2'b00};
               dmem_be    = is_store ? store_be(i_funct3, i_alu_result[1:0]) : 4'b1111;
               dmem_wdata = is_store ? store_wdata(i_funct3, i_rf_data2) : '0;
               if (!dmem_gnt) begin
                  state_d = WAIT_GNT;
                  o_stall = 1'b1;
               end else if (!is_store) begin
                  state_d = WAIT_RVALID;
                  o_stall = 1'b1;
               end
            end
         end
         WAIT_GNT: begin
            o_stall    = 1'b1;
            dmem_req   = 1'b1;
            dmem_we    = req_we_q;
            dmem_addr  = req_addr_q;
            dmem_be    = req_be_q;
            dmem_wdata = req_wdata_q;
            if (dmem_gnt) state_d = req_we_q ? IDLE : WAIT_RVALID;
         end
         WAIT_RVALID: begin
            o_stall = 1'b1;
            if (dmem_rvalid || timeout) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register and response-timeout counter (cleared outside WAIT_RVALID).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= (state_q == WAIT_RVALID) ? cnt_q + CNT_W'(1) : '0;
      end
   end

   // Capture the request in the IDLE issue cycle so WAIT_GNT can replay it unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_addr_q  <= '0;
         req_be_q    <= '0;
         req_wdata_q <= '0;
         req_we_q    <= 1'b0;
         req_f3_q    <= '0;
         req_off_q   <= '0;
         req_rd_q    <= '0;
      end else if (state_q == IDLE && dmem_req) begin
         req_addr_q  <= dmem_addr;
         req_be_q    <= dmem_be;
         req_wdata_q <= dmem_wdata;
         req_we_q    <= dmem_we;
         req_f3_q    <= i_funct3;
         req_off_q   <= i_alu_result[1:0];
         req_rd_q    <= i_rd;
      end
   end

   // Write-back entry and one-cycle exception pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_wb_valid       <= 1'b0;
         o_wb_data        <= '0;
         o_wb_rd          <= '0;
         o_exc_misaligned <= 1'b0;
         o_exc_bus        <= 1'b0;
      end else begin
         o_wb_valid       <= 1'b0;
         o_exc_misaligned <= 1'b0;
         o_exc_bus        <= 1'b0;
         if (state_q == IDLE && i_valid) begin
            if (!is_mem) begin
               o_wb_valid <= 1'b1;
               o_wb_data  <= i_alu_result;
               o_wb_rd    <= i_rd;
            end else if (mis_now) begin
               o_exc_misaligned <= 1'b1;
            end
         end else if (state_q == WAIT_RVALID) begin
            if (dmem_rvalid) begin
               o_wb_valid <= 1'b1;
               o_wb_data  <= load_data;
               o_wb_rd    <= req_rd_q;
            end else if (timeout) begin
               o_exc_bus <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed stimulus pushes expected
// write-back / exception events (with their cycle) into a queue; a monitor
// pops and compares each event the DUT presents.
module tb_mem_stage;
   import common::*;

   localparam int EV_WB  = 0;
   localparam int EV_MIS = 1;
   localparam int EV_BUS = 2;

   typedef struct {
      int          kind;
      logic [31:0] data;
      logic [4:0]  rd;
      int          cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic [31:0] i_alu_result;
   logic [31:0] i_rf_data2;
   logic [4:0]  i_rd;
   mem_op_type  i_mem_op;
   logic [2:0]  i_funct3;
   logic        o_stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        o_wb_valid;
   logic [31:0] o_wb_data;
   logic [4:0]  o_wb_rd;
   logic        o_exc_misaligned, o_exc_bus;

   int  pass_cnt = 0;
   int  total_cnt = 0;
   int  cyc = 0;
   ev_t exp_q[$];

   mem_stage #(.RESP_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_alu_result(i_alu_result),
      .i_rf_data2(i_rf_data2), .i_rd(i_rd), .i_mem_op(i_mem_op), .i_funct3(i_funct3),
      .o_stall(o_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .o_wb_valid(o_wb_valid),
      .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd), .o_exc_misaligned(o_exc_misaligned),
      .o_exc_bus(o_exc_bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input int kind, input logic [31:0] data, input logic [4:0] rd, input int at);
      ev_t e;
      e.kind = kind; e.data = data; e.rd = rd; e.cyc = at;
      exp_q.push_back(e);
   endtask

   // Monitor: every presented write-back or exception must match the head of the queue.
   always @(negedge clk) begin
      ev_t e;
      int  kind;
      if (o_wb_valid === 1'b1 || o_exc_misaligned === 1'b1 || o_exc_bus === 1'b1) begin
         kind = (o_wb_valid === 1'b1) ? EV_WB : (o_exc_misaligned === 1'b1) ? EV_MIS : EV_BUS;
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
         end else begin
            e = exp_q.pop_front();
            check("ev_onehot", 32'(o_wb_valid) + 32'(o_exc_misaligned) + 32'(o_exc_bus), 32'd1);
            check("ev_kind", 32'(kind), 32'(e.kind));
            check("ev_cycle", 32'(cyc), 32'(e.cyc));
            if (e.kind == EV_WB) begin
               check("wb_data", o_wb_data, e.data);
               check("wb_rd", {27'b0, o_wb_rd}, {27'b0, e.rd});
            end
         end
      end
   end

   task automatic set_instr(input mem_op_type op, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] d2, input logic [4:0] rd);
      i_valid = 1'b1; i_mem_op = op; i_funct3 = f3;
      i_alu_result = addr; i_rf_data2 = d2; i_rd = rd;
   endtask

   task automatic do_none(input logic [31:0] res, input logic [4:0] rd);
      set_instr(MEM_NONE, 3'b000, res, 32'h0, rd);
      push(EV_WB, res, rd, cyc + 1);
      #1;
      check1("none_stall", o_stall, 1'b0);
      check1("none_req", dmem_req, 1'b0);
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d2,
                           input int gd, input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wdata);
      set_instr(MEM_STORE, f3, addr, d2, 5'd9);
      for (int c = 0; c <= gd; c++) begin
         dmem_gnt = (c == gd);
         #1;
         check1("st_req", dmem_req, 1'b1);
         check1("st_we", dmem_we, 1'b1);
         check("st_addr", dmem_addr, e_addr);
         check("st_be", {28'b0, dmem_be}, {28'b0, e_be});
         check("st_wdata", dmem_wdata, e_wdata);
         check1("st_stall", o_stall, gd != 0);
         @(negedge clk);
      end
      dmem_gnt = 1'b0; i_valid = 1'b0;
      #1;
      check1("st_done_req", dmem_req, 1'b0);
      check1("st_done_stall", o_stall, 1'b0);
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input int gd, input int rdly, input logic spur,
                          input logic [31:0] rdata, input logic [31:0] exp);
      set_instr(MEM_LOAD, f3, addr, 32'hA5A5_A5A5, rd);
      push(EV_WB, exp, rd, cyc + gd + rdly + 2);
      for (int c = 0; c <= gd; c++) begin
         dmem_gnt    = (c == gd);
         dmem_rvalid = spur && (c == gd);
         dmem_rdata  = ~rdata;
         #1;
         check1("ld_req", dmem_req, 1'b1);
         check1("ld_we", dmem_we, 1'b0);
         check("ld_addr", dmem_addr, {addr[31:2], 2'b00});
         check("ld_be", {28'b0, dmem_be}, 32'hF);
         check1("ld_stall", o_stall, 1'b1);
         @(negedge clk);
      end
      dmem_gnt = 1'b0;
      for (int c = 0; c <= rdly; c++) begin
         dmem_rvalid = (c == rdly);
         dmem_rdata  = (c == rdly) ? rdata : ~rdata;
         #1;
         check1("ldw_req", dmem_req, 1'b0);
         check1("ldw_stall", o_stall, 1'b1);
         @(negedge clk);
      end
      dmem_rvalid = 1'b0; i_valid = 1'b0;
      #1;
      check1("ld_done_stall", o_stall, 1'b0);
   endtask

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_alu_result = '0; i_rf_data2 = '0; i_rd = '0;
      i_mem_op = MEM_NONE; i_funct3 = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check1("rst_stall", o_stall, 1'b0);
      check1("rst_req", dmem_req, 1'b0);
      check("rst_dmem", {dmem_we, dmem_be, 27'b0} | dmem_addr | dmem_wdata, 32'h0);
      check1("rst_wb_valid", o_wb_valid, 1'b0);
      check("rst_wb_data", o_wb_data, 32'h0);
      check("rst_wb_rd", {27'b0, o_wb_rd}, 32'h0);
      check("rst_exc", {30'b0, o_exc_misaligned, o_exc_bus}, 32'h0);
      @(negedge clk);

      do_none(32'h1234_5678, 5'd5);
      do_none(32'hFFFF_0001, 5'd31);
      @(negedge clk);

      do_store(F3_SB, 32'h0000_0103, 32'h0000_00AB, 0, 32'h100, 4'b1000, 32'hABAB_ABAB);
      do_store(F3_SH, 32'h0000_0102, 32'h1234_BEEF, 1, 32'h100, 4'b1100, 32'hBEEF_BEEF);
      do_store(F3_SW, 32'h0000_0208, 32'hDEAD_BEEF, 0, 32'h208, 4'b1111, 32'hDEAD_BEEF);
      do_store(F3_SB, 32'h0000_0001, 32'hFFFF_FF12, 2, 32'h0,   4'b0010, 32'h1212_1212);

      do_load(F3_LB,  32'h0000_0102, 5'd7, 3, 0, 1'b0, 32'h0080_0000, 32'hFFFF_FF80);
      do_load(F3_LBU, 32'h0000_0102, 5'd8, 3, 0, 1'b0, 32'h0080_0000, 32'h0000_0080);
      do_load(F3_LW,  32'h0000_0104, 5'd1, 0, 0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      do_load(F3_LH,  32'h0000_0102, 5'd2, 0, 2, 1'b0, 32'h8001_1234, 32'hFFFF_8001);
      do_load(F3_LHU, 32'h0000_0100, 5'd3, 1, 0, 1'b0, 32'h8001_F234, 32'h0000_F234);
      do_load(F3_LB,  32'h0000_0101, 5'd4, 0, 0, 1'b0, 32'h0000_7F00, 32'h0000_007F);
      do_load(F3_LB,  32'h0000_0103, 5'd6, 0, 1, 1'b0, 32'hFE00_0000, 32'hFFFF_FFFE);
      // Grant and rvalid together in IDLE: rvalid must be ignored.
      do_load(F3_LW,  32'h0000_0104, 5'd10, 0, 1, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D);

      // Misaligned accesses.
      set_instr(MEM_LOAD, F3_LW, 32'h0000_0101, 32'h0, 5'd11);
      push(EV_MIS, 32'h0, 5'd0, cyc + 1);
      #1;
      check1("mis_lw_req", dmem_req, 1'b0);
      check1("mis_lw_stall", o_stall, 1'b0);
      @(negedge clk);
      set_instr(MEM_STORE, F3_SH, 32'h0000_0203, 32'h1111, 5'd0);
      push(EV_MIS, 32'h0, 5'd0, cyc + 1);
      #1;
      check1("mis_sh_req", dmem_req, 1'b0);
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);

      // Response timeout (RESP_TIMEOUT = 4): bus error 5 cycles after the grant.
      set_instr(MEM_LOAD, F3_LW, 32'h0000_0200, 32'h0, 5'd12);
      dmem_gnt = 1'b1;
      push(EV_BUS, 32'h0, 5'd0, cyc + 5);
      #1;
      check1("to_stall0", o_stall, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         dmem_gnt = 1'b0;
         #1;
         check1("to_stall", o_stall, 1'b1);
         check1("to_req", dmem_req, 1'b0);
      end
      @(negedge clk);
      i_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
      #1;
      check1("to_idle_stall", o_stall, 1'b0);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      @(negedge clk);

      // Reset while waiting for rvalid; the late response must be dropped.
      set_instr(MEM_LOAD, F3_LH, 32'h0000_0100, 32'h0, 5'd13);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0; rst = 1'b1;
      #1;
      check1("ab_stall_pre", o_stall, 1'b1);
      @(negedge clk);
      rst = 1'b0; i_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
      #1;
      check1("ab_stall", o_stall, 1'b0);
      check1("ab_req", dmem_req, 1'b0);
      check1("ab_wb_valid", o_wb_valid, 1'b0);
      check("ab_wb_data", o_wb_data, 32'h0);
      check("ab_wb_rd", {27'b0, o_wb_rd}, 32'h0);
      @(negedge clk);
      dmem_rvalid = 1'b0;
      #1;
      check1("ab_no_wb", o_wb_valid, 1'b0);
      repeat (3) @(negedge clk);

      check("sb_empty", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
